// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: holds the PC, issues one-at-a-time read requests to
// the L1-I, buffers returned {pc, instr} pairs in a 2-entry FIFO toward decode,
// and sequences branch redirects and fence.i-driven cache flushes.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | no request outstanding; decide between flush, fetch or wait
// S_REQ   | read strobe to L1-I for exactly one cycle
// S_WAIT  | waiting for the word of the outstanding request
// S_DRAIN | outstanding request is stale (redirected); discard its word
// S_FLUSH | one-cycle L1-I invalidate pulse, clears the pending fence
module instr_fetch_unit #(
   parameter int                ADDR_W     = 32,
   parameter int                TAG_W      = 20,
   parameter int                INDEX_W    = 6,
   parameter int                OFFSET_W   = 6,
   parameter logic [ADDR_W-1:0] RESET_PC   = 32'h0000_0000,
   parameter int                FIFO_DEPTH = 2
) (
   input  logic                clk,
   input  logic                nrst,
   input  logic                enable,
   input  logic                redirect,
   input  logic [ADDR_W-1:0]   redirect_pc,
   input  logic                fence_i,
   input  logic                stall,
   input  logic                instr_valid_in,
   input  logic [31:0]         instr_in,
   output logic [TAG_W-1:0]    tag,
   output logic [INDEX_W-1:0]  index,
   output logic [OFFSET_W-1:0] offset,
   output logic                read_C_L1,
   output logic                write_C_L1,
   output logic                flush,
   output logic [31:0]         inst_out,
   output logic [ADDR_W-1:0]   pc_out,
   output logic                inst_valid,
   input  logic                inst_ready
);

   typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_DRAIN, S_FLUSH} state_t;

   state_t              state, state_next;
   logic [ADDR_W-1:0]   pc, pc_next;
   logic [ADDR_W-1:0]   req_addr;
   logic                fence_pending;
   logic [ADDR_W-1:0]   fifo_pc    [2];
   logic [31:0]         fifo_instr [2];
   logic                wr_ptr, rd_ptr;
   logic [1:0]          count, count_after;
   logic                push, pop, fence_req, idle_issue, wait_issue;

   // A redirect empties the FIFO, so a pop in the same cycle is lost.
   assign pop         = inst_valid && inst_ready && !redirect;
   assign push        = (state == S_WAIT) && instr_valid_in && !redirect;
   assign count_after = count + 2'(push) - 2'(pop);
   // A fence that is pending or arriving now blocks new fetches until flushed.
   assign fence_req   = fence_pending || fence_i;
   assign idle_issue  = enable && !stall && !fence_req && (int'(count) < FIFO_DEPTH);
   assign wait_issue  = enable && !stall && !fence_req && (int'(count_after) < FIFO_DEPTH);

   // Next-state and PC update; redirect overrides everything else.
   always_comb begin
      state_next = state;
      pc_next    = pc;
      case (state)
         S_IDLE: begin
            if (fence_pending)   state_next = S_FLUSH;
            else if (idle_issue) state_next = S_REQ;
         end
         S_REQ:   state_next = S_WAIT;
         S_WAIT: begin
            if (instr_valid_in) begin
               pc_next    = pc + ADDR_W'(4);
               state_next = wait_issue ? S_REQ : S_IDLE;
            end
         end
         S_DRAIN: begin
            if (instr_valid_in) state_next = S_IDLE;
         end
         S_FLUSH: state_next = S_IDLE;
         default: state_next = S_IDLE;
      endcase
      if (redirect) begin
         pc_next = redirect_pc & ~ADDR_W'(3);
         case (state)
            S_REQ:   state_next = S_DRAIN;
            S_WAIT:  state_next = instr_valid_in ? S_IDLE : S_DRAIN;
            // The stale word may land in the same cycle as a second redirect.
            S_DRAIN: state_next = instr_valid_in ? S_IDLE : S_DRAIN;
            default: state_next = S_IDLE;
         endcase
      end
   end

   // FSM, PC, request address and sticky fence flag.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state         <= S_IDLE;
         pc            <= RESET_PC;
         req_addr      <= RESET_PC;
         fence_pending <= 1'b0;
      end else begin
         state <= state_next;
         pc    <= pc_next;
         // Latch the address as the request issues so it holds through the wait.
         if (state_next == S_REQ) req_addr <= pc_next;
         if (fence_i)                fence_pending <= 1'b1;
         else if (state == S_FLUSH)  fence_pending <= 1'b0;
      end
   end

   // Two-entry output FIFO toward decode.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         wr_ptr        <= 1'b0;
         rd_ptr        <= 1'b0;
         count         <= 2'd0;
         fifo_pc[0]    <= '0;
         fifo_pc[1]    <= '0;
         fifo_instr[0] <= '0;
         fifo_instr[1] <= '0;
      end else if (redirect) begin
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         count  <= 2'd0;
      end else begin
         if (push) begin
            fifo_pc[wr_ptr]    <= pc;
            fifo_instr[wr_ptr] <= instr_in;
            wr_ptr             <= ~wr_ptr;
         end
         if (pop) rd_ptr <= ~rd_ptr;
         count <= count_after;
      end
   end

   assign tag        = req_addr[ADDR_W-1 -: TAG_W];
   assign index      = req_addr[OFFSET_W +: INDEX_W];
   assign offset     = req_addr[OFFSET_W-1:0];
   assign read_C_L1  = (state == S_REQ);
   assign flush      = (state == S_FLUSH);
   assign write_C_L1 = 1'b0;
   assign inst_valid = (count != 2'd0);
   assign inst_out   = inst_valid ? fifo_instr[rd_ptr] : '0;
   assign pc_out     = inst_valid ? fifo_pc[rd_ptr] : '0;

endmodule
